// File: rtl/rx_core_cfg_pkg.sv
// rx_core_cfg_pkg: shared widths, cfg address map and sequencer state encoding
package rx_core_cfg_pkg;
  localparam int PINC_W = 16;
  localparam int DUC_GAIN_W = 8;
  localparam int DEMIX_GAIN_W = 16;
  typedef enum logic [3:0] {
    CFG_DDC_PINC   = 4'd0,
    CFG_DEMIX_GAIN = 4'd1,
    CFG_DEMIX_PINC = 4'd2,
    CFG_DUC1_PINC  = 4'd3,
    CFG_DUC2_PINC  = 4'd4,
    CFG_DUC3_PINC  = 4'd5,
    CFG_GAIN_DUC1  = 4'd6,
    CFG_GAIN_DUC2  = 4'd7,
    CFG_GAIN_DUC3  = 4'd8
  } cfg_addr_e;
  typedef enum logic [1:0] {ST_IDLE, ST_APPLY, ST_RAMP, ST_SETTLE} state_e;
endpackage

// File: rtl/rx_core_cfg_sequencer_gain_ramp.sv
// gain_ramp: steps value toward a latched target on tick (clock, reset, target/load latch, step/tick move; value, at_target = target reached after this edge)
module gain_ramp #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] target,
  input  logic [7:0]       step,
  input  logic             tick,
  input  logic             load,
  output logic [WIDTH-1:0] value,
  output logic             at_target
);
  logic [WIDTH-1:0] tgt, stp, diff, nxt;
  assign stp = WIDTH'(step);
  assign diff = value > tgt ? value - tgt : tgt - value;
  assign nxt = !tick ? value : diff <= stp ? tgt : value > tgt ? value - stp : value + stp;
  assign at_target = load ? value == target : nxt == tgt;
  always_ff @(posedge clock) begin
    if (reset) begin
      value <= '0;
      tgt <= '0;
    end else begin
      if (load) tgt <= target;
      value <= nxt;
    end
  end
endmodule

// File: rtl/rx_core_cfg_sequencer.sv
// rx_core_cfg_sequencer: shadowed rx config with atomic phase-inc commit, ramped gains and settle flag (cfg_* write port, commit, busy/settled/cfg_error status, active config outputs)
module rx_core_cfg_sequencer
  import rx_core_cfg_pkg::*;
#(
  parameter int RAMP_STEP = 1,
  parameter int RAMP_INTERVAL = 16,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [3:0]              cfg_addr,
  input  logic [15:0]             cfg_data,
  input  logic                    commit,
  output logic                    busy,
  output logic                    settled,
  output logic                    cfg_error,
  output logic [PINC_W-1:0]       ddc_phase_inc,
  output logic [PINC_W-1:0]       demix_phase_inc,
  output logic [PINC_W-1:0]       duc1_phase_inc,
  output logic [PINC_W-1:0]       duc2_phase_inc,
  output logic [PINC_W-1:0]       duc3_phase_inc,
  output logic [DEMIX_GAIN_W-1:0] demix_gain,
  output logic [DUC_GAIN_W-1:0]   gain_duc1,
  output logic [DUC_GAIN_W-1:0]   gain_duc2,
  output logic [DUC_GAIN_W-1:0]   gain_duc3
);
  state_e state;
  logic pending, wr, tick, load, all_at;
  logic [15:0] cnt;
  logic [15:0] sh_w [6];
  logic [DUC_GAIN_W-1:0] sh_g [3];
  logic [3:0] at;
  assign cfg_ready = state == ST_IDLE && !reset;
  assign busy = state != ST_IDLE;
  assign wr = cfg_valid && cfg_ready;
  assign load = state == ST_APPLY;
  assign tick = state == ST_RAMP && cnt == 16'(RAMP_INTERVAL - 1);
  assign all_at = &at;
  gain_ramp #(.WIDTH(DEMIX_GAIN_W)) u_demix (.clock(clock), .reset(reset), .target(sh_w[1]), .step(8'(RAMP_STEP)), .tick(tick), .load(load), .value(demix_gain), .at_target(at[0]));
  gain_ramp #(.WIDTH(DUC_GAIN_W)) u_duc1 (.clock(clock), .reset(reset), .target(sh_g[0]), .step(8'(RAMP_STEP)), .tick(tick), .load(load), .value(gain_duc1), .at_target(at[1]));
  gain_ramp #(.WIDTH(DUC_GAIN_W)) u_duc2 (.clock(clock), .reset(reset), .target(sh_g[1]), .step(8'(RAMP_STEP)), .tick(tick), .load(load), .value(gain_duc2), .at_target(at[2]));
  gain_ramp #(.WIDTH(DUC_GAIN_W)) u_duc3 (.clock(clock), .reset(reset), .target(sh_g[2]), .step(8'(RAMP_STEP)), .tick(tick), .load(load), .value(gain_duc3), .at_target(at[3]));
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      pending <= 1'b0;
      cnt <= '0;
      settled <= 1'b0;
      cfg_error <= 1'b0;
      for (int i = 0; i < 6; i++) sh_w[i] <= '0;
      for (int i = 0; i < 3; i++) sh_g[i] <= '0;
      ddc_phase_inc <= '0;
      demix_phase_inc <= '0;
      duc1_phase_inc <= '0;
      duc2_phase_inc <= '0;
      duc3_phase_inc <= '0;
    end else begin
      cfg_error <= wr && cfg_addr > CFG_GAIN_DUC3;
      for (int i = 0; i < 6; i++) if (wr && cfg_addr == 4'(i)) sh_w[i] <= cfg_data;
      for (int i = 0; i < 3; i++) if (wr && cfg_addr == 4'(i + 6)) sh_g[i] <= cfg_data[7:0];
      pending <= state != ST_IDLE && (pending || commit);
      case (state)
        ST_IDLE: if (commit || pending) state <= ST_APPLY;
        ST_APPLY: begin
          ddc_phase_inc <= sh_w[0];
          demix_phase_inc <= sh_w[2];
          duc1_phase_inc <= sh_w[3];
          duc2_phase_inc <= sh_w[4];
          duc3_phase_inc <= sh_w[5];
          settled <= 1'b0;
          cnt <= '0;
          state <= all_at ? ST_SETTLE : ST_RAMP;
        end
        ST_RAMP: begin
          cnt <= tick ? 16'd0 : cnt + 16'd1;
          if (tick && all_at) state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          cnt <= cnt + 16'd1;
          if (cnt == 16'(SETTLE_CYCLES - 1)) begin
            state <= ST_IDLE;
            settled <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rx_core_cfg_sequencer.sv
// tb_rx_core_cfg_sequencer: random cfg traffic checked every cycle against a timeline model of the sequencer
module tb_rx_core_cfg_sequencer;
  localparam int RS = 48;
  localparam int RI = 4;
  localparam int SC = 12;
  logic clock = 0, reset = 1, cfg_valid = 0, commit = 0;
  logic [3:0] cfg_addr = 0;
  logic [15:0] cfg_data = 0;
  logic cfg_ready, busy, settled, cfg_error;
  logic [15:0] ddc_phase_inc, demix_phase_inc, duc1_phase_inc, duc2_phase_inc, duc3_phase_inc, demix_gain;
  logic [7:0] gain_duc1, gain_duc2, gain_duc3;
  int total = 0, bad = 0;
  int n = 0, e1 = -1, e_end = -1, nt = 0;
  bit m_busy, m_pend, m_set, m_err;
  int m_sh [9];
  int m_ph [5];
  int g_start [4], g_tgt [4], g_cur [4];
  always #5 clock = ~clock;
  rx_core_cfg_sequencer #(.RAMP_STEP(RS), .RAMP_INTERVAL(RI), .SETTLE_CYCLES(SC)) dut (
    .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .commit(commit), .busy(busy), .settled(settled), .cfg_error(cfg_error),
    .ddc_phase_inc(ddc_phase_inc), .demix_phase_inc(demix_phase_inc), .duc1_phase_inc(duc1_phase_inc),
    .duc2_phase_inc(duc2_phase_inc), .duc3_phase_inc(duc3_phase_inc), .demix_gain(demix_gain),
    .gain_duc1(gain_duc1), .gain_duc2(gain_duc2), .gain_duc3(gain_duc3));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask
  function automatic int move(input int s, input int t, input int amt);
    return t >= s ? (s + amt > t ? t : s + amt) : (s - amt < t ? t : s - amt);
  endfunction
  task automatic model_edge();
    bit idle;
    int d, k;
    n++;
    if (reset) begin
      m_busy = 0; m_pend = 0; m_set = 0; m_err = 0; e1 = -1;
      foreach (m_sh[i]) m_sh[i] = 0;
      foreach (m_ph[i]) m_ph[i] = 0;
      foreach (g_cur[i]) begin g_cur[i] = 0; g_start[i] = 0; g_tgt[i] = 0; end
      return;
    end
    idle = !m_busy;
    m_err = 0;
    if (cfg_valid && idle) begin
      if (cfg_addr < 9) m_sh[cfg_addr] = cfg_addr >= 6 ? int'(cfg_data) % 256 : int'(cfg_data);
      else m_err = 1;
    end
    if (idle && (commit || m_pend)) begin
      m_busy = 1; e1 = n + 1; m_pend = 0;
    end else if (!idle && commit) m_pend = 1;
    if (m_busy && n == e1) begin
      m_ph[0] = m_sh[0]; m_ph[1] = m_sh[2]; m_ph[2] = m_sh[3]; m_ph[3] = m_sh[4]; m_ph[4] = m_sh[5];
      g_tgt[0] = m_sh[1]; g_tgt[1] = m_sh[6]; g_tgt[2] = m_sh[7]; g_tgt[3] = m_sh[8];
      m_set = 0; nt = 0;
      for (int i = 0; i < 4; i++) begin
        g_start[i] = g_cur[i];
        d = g_tgt[i] > g_cur[i] ? g_tgt[i] - g_cur[i] : g_cur[i] - g_tgt[i];
        k = (d + RS - 1) / RS;
        if (k > nt) nt = k;
      end
      e_end = e1 + nt * RI + SC;
    end
    if (m_busy && n > e1 && n <= e1 + nt * RI && (n - e1) % RI == 0)
      for (int i = 0; i < 4; i++) g_cur[i] = move(g_start[i], g_tgt[i], (n - e1) / RI * RS);
    if (m_busy && n == e_end) begin
      m_busy = 0; m_set = 1;
    end
  endtask
  task automatic cycle();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    chk("ddc_pinc", ddc_phase_inc, m_ph[0]);
    chk("demix_pinc", demix_phase_inc, m_ph[1]);
    chk("duc1_pinc", duc1_phase_inc, m_ph[2]);
    chk("duc2_pinc", duc2_phase_inc, m_ph[3]);
    chk("duc3_pinc", duc3_phase_inc, m_ph[4]);
    chk("demix_gain", demix_gain, g_cur[0]);
    chk("gain_duc1", gain_duc1, g_cur[1]);
    chk("gain_duc2", gain_duc2, g_cur[2]);
    chk("gain_duc3", gain_duc3, g_cur[3]);
    chk("busy", busy, m_busy);
    chk("settled", settled, m_set);
    chk("cfg_error", cfg_error, m_err);
    chk("cfg_ready", cfg_ready, !m_busy && !reset);
  endtask
  task automatic drive(input bit v, input int a, input int d, input bit c, input bit r);
    cfg_valid = v; cfg_addr = 4'(a); cfg_data = 16'(d); commit = c; reset = r;
    cycle();
  endtask
  initial begin
    repeat (3) drive(0, 0, 0, 0, 1);
    drive(1, 0, 'h1234, 1, 0);
    for (int i = 0; i < 200 && busy; i++) drive(0, 0, 0, 0, 0);
    chk("t1_ddc", ddc_phase_inc, 16'h1234);
    chk("t1_settled", settled, 1);
    chk("t1_duc1", gain_duc1, 0);
    drive(1, 1, 'h0100, 0, 0);
    drive(1, 6, 'h00c5, 1, 0);
    for (int i = 0; i < 200 && busy; i++) drive(0, 0, 0, i == 5 || i == 30, 0);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 200 && busy; i++) drive(0, 0, 0, 0, 0);
    chk("t3_demix", demix_gain, 16'h0100);
    chk("t3_duc1", gain_duc1, 8'hc5);
    drive(1, 12, 'hffff, 0, 0);
    drive(1, 1, 'h0010, 1, 0);
    for (int i = 0; i < 200 && busy; i++) drive(0, 0, 0, 0, 0);
    chk("t3_demix_down", demix_gain, 16'h0010);
    for (int i = 0; i < 9000; i++) begin
      int a, d;
      a = $urandom_range(0, 15);
      d = $urandom_range(0, 65535);
      if (a == 1) d = d % 4096;
      drive($urandom_range(0, 2) == 0, a, d, $urandom_range(0, 39) == 0, $urandom_range(0, 799) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
